// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types and constants for the HD44780 16x2 init/refresh
//               sequencer: FSM state encoding, init command bytes,
//               line-address commands and refresh-slot decoding helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Width of the delay counters (enough for 15 ms at 50 MHz).
    localparam int c_delay_w    = 20;

    // Init sequence length and per-line character count.
    localparam int c_init_len   = 4;
    localparam int c_line_chars = 16;

    // One refresh pass: line-1 address, 16 chars, line-2 address, 16 chars.
    localparam int c_ref_len    = 34;

    // Init commands, issued in this order with rs=0.
    localparam logic [7:0] c_cmd_function_set = 8'h38;  // 8-bit, 2 lines, 5x8
    localparam logic [7:0] c_cmd_entry_mode   = 8'h06;  // increment, no shift
    localparam logic [7:0] c_cmd_display_on   = 8'h0C;  // display on, no cursor
    localparam logic [7:0] c_cmd_clear        = 8'h01;  // clear display

    // Set-DDRAM-address commands for the start of each line.
    localparam logic [7:0] c_cmd_line1 = 8'h80;
    localparam logic [7:0] c_cmd_line2 = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PWR_WAIT   = 3'd1,
        ST_INIT_ISSUE = 3'd2,
        ST_INIT_WAIT  = 3'd3,
        ST_CLR_DELAY  = 3'd4,
        ST_REF_ISSUE  = 3'd5,
        ST_REF_WAIT   = 3'd6
    } lcd_state_t;

    // Command byte for a given init step.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = c_cmd_function_set;
            2'd1:    cmd = c_cmd_entry_mode;
            2'd2:    cmd = c_cmd_display_on;
            default: cmd = c_cmd_clear;
        endcase
        return cmd;
    endfunction

    // Refresh slots 0 and 17 carry the line-address commands.
    function automatic logic ref_is_cmd(input logic [5:0] r);
        return (r == 6'd0) || (r == 6'(c_line_chars + 1));
    endfunction

    // Buffer address for a character slot. The 5-bit subtraction wraps
    // correctly for slots 32/33 (-> 30/31).
    function automatic logic [4:0] ref_char_addr(input logic [5:0] r);
        return (r <= 6'(c_line_chars)) ? (r[4:0] - 5'd1) : (r[4:0] - 5'd2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_init_refresh_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_refresh_if
// Description : Bundle between the LCD sequencer and its surroundings: the
//               enable/status pair, the byte-write handshake to the low-level
//               LCD write module and the character-buffer read port.
//   lcd_enable  : run request (level)
//   wr_start    : one-cycle byte write request
//   wr_data     : byte to write, stable from wr_start until wr_finish
//   wr_rs       : 0 = command, 1 = character data
//   wr_finish   : one-cycle completion pulse from the write module
//   char_addr   : buffer address (0..15 line 1, 16..31 line 2)
//   char_data   : asynchronous-read buffer data for char_addr
//   init_done   : init sequence complete, refreshing
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_init_refresh_if;

    logic       lcd_enable;
    logic       wr_start;
    logic [7:0] wr_data;
    logic       wr_rs;
    logic       wr_finish;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic       init_done;

    // Sequencer side.
    modport master (
        input  lcd_enable,
        input  wr_finish,
        input  char_data,
        output wr_start,
        output wr_data,
        output wr_rs,
        output char_addr,
        output init_done
    );

    // Environment side (write module, buffer, controller).
    modport slave (
        output lcd_enable,
        output wr_finish,
        output char_data,
        input  wr_start,
        input  wr_data,
        input  wr_rs,
        input  char_addr,
        input  init_done
    );

endinterface
`default_nettype wire

// File: rtl/lcd_delay_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_delay_timer
// Description : Single-shot cycle delay. A start pulse latches the terminal
//               count; o_done is high during the terminal-count-th cycle
//               after start, so a consumer moving on when o_done is seen
//               spends exactly that many cycles waiting. A terminal count of
//               0 behaves as 1. A new start always restarts the count.
//   clk, rst    : clock, asynchronous active-high reset
//   i_start     : restart the delay
//   i_terminal  : delay length in clk cycles (sampled with i_start)
//   o_done      : one-cycle pulse in the final cycle of the delay
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_delay_timer #(
    parameter int DELAY_W = 20
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_start,
    input  wire logic [DELAY_W-1:0] i_terminal,
    output logic                    o_done
);

    localparam logic [DELAY_W-1:0] c_one = DELAY_W'(1);

    logic [DELAY_W-1:0] r_count;
    logic [DELAY_W-1:0] r_terminal;
    logic               r_busy;
    logic [DELAY_W-1:0] w_terminal_eff;

    assign w_terminal_eff = (i_terminal == '0) ? c_one : i_terminal;

    // r_count holds the number of the cycle currently in progress (1-based),
    // so it never needs to exceed the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_terminal <= '0;
            r_busy     <= 1'b0;
        end else if (i_start) begin
            r_count    <= c_one;
            r_terminal <= w_terminal_eff;
            r_busy     <= 1'b1;
        end else if (o_done) begin
            r_busy     <= 1'b0;
        end else if (r_busy) begin
            r_count    <= r_count + c_one;
        end
    end

    assign o_done = r_busy && (r_count >= r_terminal);

endmodule
`default_nettype wire

// File: rtl/lcd_init_refresh.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_refresh
// Description : HD44780 16x2 (8-bit mode) sequencer. After lcd_enable it
//               waits POWERUP_CYCLES, sends the init commands, waits
//               CLEAR_CYCLES after the clear, then refreshes both lines from
//               a 32-byte character buffer forever. Each byte is requested
//               with a one-cycle wr_start and completed by wr_finish.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   bus         : lcd_init_refresh_if.master (enable, write handshake,
//                 buffer read port, init_done)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_init_refresh
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES = 750000,
    parameter int CLEAR_CYCLES   = 82000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lcd_init_refresh_if.master bus
);

    localparam logic [c_delay_w-1:0] c_powerup_tc = c_delay_w'(POWERUP_CYCLES);
    localparam logic [c_delay_w-1:0] c_clear_tc   = c_delay_w'(CLEAR_CYCLES);
    localparam logic [1:0]           c_init_last  = 2'(c_init_len - 1);
    localparam logic [5:0]           c_ref_last   = 6'(c_ref_len - 1);

    lcd_state_t           r_state;
    lcd_state_t           w_next_state;
    logic [1:0]           r_init_idx;
    logic [5:0]           r_ref_idx;
    logic [7:0]           r_data_hold;
    logic                 r_rs_hold;
    logic                 r_init_done;

    logic                 w_issuing;
    logic                 w_ref_cmd;
    logic [7:0]           w_issue_data;
    logic                 w_issue_rs;

    logic                 w_timer_start;
    logic [c_delay_w-1:0] w_timer_tc;
    logic                 w_timer_done;

    // One timer serves both the power-up and post-clear delays; they never
    // overlap and each is (re)started on entry to its wait state.
    lcd_delay_timer #(
        .DELAY_W    (c_delay_w)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_timer_start),
        .i_terminal (w_timer_tc),
        .o_done     (w_timer_done)
    );

    assign w_ref_cmd = ref_is_cmd(r_ref_idx);
    assign w_issuing = (r_state == ST_INIT_ISSUE) || (r_state == ST_REF_ISSUE);

    // --------------------------------------------------------------------
    // Byte presented on the bus. During an ISSUE cycle it is the freshly
    // selected byte (buffer data is read combinationally right here);
    // afterwards the captured copy keeps it stable until wr_finish.
    // --------------------------------------------------------------------
    always_comb begin : issue_byte
        w_issue_data = r_data_hold;
        w_issue_rs   = r_rs_hold;
        if (r_state == ST_INIT_ISSUE) begin
            w_issue_data = init_cmd(r_init_idx);
            w_issue_rs   = 1'b0;
        end else if (r_state == ST_REF_ISSUE) begin
            if (w_ref_cmd) begin
                w_issue_data = (r_ref_idx == 6'd0) ? c_cmd_line1 : c_cmd_line2;
                w_issue_rs   = 1'b0;
            end else begin
                w_issue_data = bus.char_data;
                w_issue_rs   = 1'b1;
            end
        end
    end

    // An ISSUE cycle that is being abandoned because enable dropped does not
    // raise wr_start, so no write is left in flight when going idle.
    assign bus.wr_start  = w_issuing && bus.lcd_enable;
    assign bus.wr_data   = w_issue_data;
    assign bus.wr_rs     = w_issue_rs;
    assign bus.char_addr = ((r_state == ST_REF_ISSUE) && !w_ref_cmd) ?
                           ref_char_addr(r_ref_idx) : 5'd0;
    assign bus.init_done = r_init_done;

    // --------------------------------------------------------------------
    // Next-state logic. wr_finish is only looked at in the WAIT states, so
    // a pulse coinciding with wr_start (ISSUE) or outside a write is ignored.
    // --------------------------------------------------------------------
    always_comb begin : next_state
        w_next_state  = r_state;
        w_timer_start = 1'b0;
        w_timer_tc    = c_powerup_tc;
        case (r_state)
            ST_IDLE: begin
                if (bus.lcd_enable) begin
                    w_next_state  = ST_PWR_WAIT;
                    w_timer_start = 1'b1;
                    w_timer_tc    = c_powerup_tc;
                end
            end
            ST_PWR_WAIT: begin
                if (!bus.lcd_enable)
                    w_next_state = ST_IDLE;
                else if (w_timer_done)
                    w_next_state = ST_INIT_ISSUE;
            end
            ST_INIT_ISSUE: begin
                w_next_state = bus.lcd_enable ? ST_INIT_WAIT : ST_IDLE;
            end
            ST_INIT_WAIT: begin
                // A disable is honoured only once the write in flight ends.
                if (bus.wr_finish) begin
                    if (!bus.lcd_enable) begin
                        w_next_state = ST_IDLE;
                    end else if (r_init_idx == c_init_last) begin
                        w_next_state  = ST_CLR_DELAY;
                        w_timer_start = 1'b1;
                        w_timer_tc    = c_clear_tc;
                    end else begin
                        w_next_state = ST_INIT_ISSUE;
                    end
                end
            end
            ST_CLR_DELAY: begin
                if (!bus.lcd_enable)
                    w_next_state = ST_IDLE;
                else if (w_timer_done)
                    w_next_state = ST_REF_ISSUE;
            end
            ST_REF_ISSUE: begin
                w_next_state = bus.lcd_enable ? ST_REF_WAIT : ST_IDLE;
            end
            ST_REF_WAIT: begin
                if (bus.wr_finish)
                    w_next_state = bus.lcd_enable ? ST_REF_ISSUE : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // --------------------------------------------------------------------
    // Indices, byte capture and init_done.
    // --------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_idx  <= 2'd0;
            r_ref_idx   <= 6'd0;
            r_data_hold <= 8'h00;
            r_rs_hold   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            if (bus.wr_start) begin
                r_data_hold <= w_issue_data;
                r_rs_hold   <= w_issue_rs;
            end

            if (r_state == ST_IDLE)
                r_init_idx <= 2'd0;
            else if ((r_state == ST_INIT_WAIT) && (w_next_state == ST_INIT_ISSUE))
                r_init_idx <= r_init_idx + 2'd1;

            if ((r_state == ST_CLR_DELAY) && (w_next_state == ST_REF_ISSUE))
                r_ref_idx <= 6'd0;
            else if ((r_state == ST_REF_WAIT) && (w_next_state == ST_REF_ISSUE))
                r_ref_idx <= (r_ref_idx == c_ref_last) ? 6'd0 : r_ref_idx + 6'd1;

            if ((w_next_state == ST_IDLE) && (r_state != ST_IDLE))
                r_init_done <= 1'b0;
            else if ((r_state == ST_CLR_DELAY) && (w_next_state == ST_REF_ISSUE))
                r_init_done <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_init_refresh.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_init_refresh
// Description : Self-checking bench for lcd_init_refresh. Plays the byte
//               write module (answers wr_start with wr_finish after a chosen
//               latency) and the character buffer, and compares every byte
//               against a per-lap list of what the display must receive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_init_refresh;

    localparam int POWERUP = 10;
    localparam int CLEAR   = 5;
    localparam int TIMEOUT = 200;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [4:0] addr;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem [32];
    logic [7:0] init_cmds [4] = '{8'h38, 8'h06, 8'h0C, 8'h01};
    int         n_assert = 0;
    int         n_fail   = 0;
    int         k;
    int         lat;
    wr_t        exp_q [$];

    lcd_init_refresh_if bus ();

    lcd_init_refresh #(
        .POWERUP_CYCLES (POWERUP),
        .CLEAR_CYCLES   (CLEAR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.char_data = mem[bus.char_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wr_t mk(input logic rs, input logic [7:0] data, input logic [4:0] addr);
        wr_t w;
        w.rs   = rs;
        w.data = data;
        w.addr = addr;
        return w;
    endfunction

    // What the panel must see in one pass: per line, a set-DDRAM-address
    // command (line base 0x00 / 0x40) followed by that line's 16 characters.
    task automatic build_lap();
        exp_q.delete();
        for (int line = 0; line < 2; line++) begin
            exp_q.push_back(mk(1'b0, 8'h80 | 8'(line * 8'h40), 5'd0));
            for (int col = 0; col < 16; col++)
                exp_q.push_back(mk(1'b1, mem[line*16 + col], 5'(line*16 + col)));
        end
    endtask

    // Count negedges until wr_start appears; optionally pulse a stray
    // wr_finish at cycle stray_at while waiting.
    task automatic wait_first_start(input int stray_at, output int cycles);
        cycles = -1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.wr_start === 1'b1) begin
                cycles = i;
                bus.wr_finish = 1'b0;
                break;
            end
            bus.wr_finish = (i == stray_at);
        end
    endtask

    // Entered on the negedge where wr_start must be visible. Checks the
    // byte, holds the write for lat cycles while checking stability, then
    // returns on the negedge after the wr_finish pulse.
    task automatic do_write(input wr_t e, input int n_lat, input bit stray_same,
                            input int drop_at, input logic exp_done, input string tag);
        check({tag, "_start"}, 32'(bus.wr_start), 32'd1);
        check({tag, "_data"},  32'(bus.wr_data),  32'(e.data));
        check({tag, "_rs"},    32'(bus.wr_rs),    32'(e.rs));
        if (e.rs)
            check({tag, "_addr"}, 32'(bus.char_addr), 32'(e.addr));
        if (stray_same)
            bus.wr_finish = 1'b1;
        for (int i = 1; i < n_lat; i++) begin
            @(negedge clk);
            check({tag, "_hold_start"}, 32'(bus.wr_start),  32'd0);
            check({tag, "_hold_data"},  32'(bus.wr_data),   32'(e.data));
            check({tag, "_hold_rs"},    32'(bus.wr_rs),     32'(e.rs));
            check({tag, "_hold_done"},  32'(bus.init_done), 32'(exp_done));
            bus.wr_finish = 1'b0;
            if (i == drop_at)
                bus.lcd_enable = 1'b0;
        end
        @(negedge clk);
        bus.wr_finish = 1'b1;
        @(negedge clk);
        bus.wr_finish = 1'b0;
    endtask

    initial begin
        bus.lcd_enable = 1'b0;
        bus.wr_finish  = 1'b0;
        for (int i = 0; i < 32; i++)
            mem[i] = 8'(8'h41 + i);

        // ---- reset state ----
        @(negedge clk);
        check("rst_wr_start",  32'(bus.wr_start),  32'd0);
        check("rst_wr_data",   32'(bus.wr_data),   32'h00);
        check("rst_wr_rs",     32'(bus.wr_rs),     32'd0);
        check("rst_char_addr", 32'(bus.char_addr), 32'd0);
        check("rst_init_done", 32'(bus.init_done), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_start", 32'(bus.wr_start), 32'd0);
        end

        // ---- power-up wait, with a stray wr_finish while waiting ----
        bus.lcd_enable = 1'b1;
        wait_first_start(5, k);
        check("powerup_latency", 32'(k), 32'(POWERUP + 1));

        // ---- init command order ----
        for (int i = 0; i < 4; i++)
            do_write(mk(1'b0, init_cmds[i], 5'd0), 3, 1'b0, -1, 1'b0, "init");

        // ---- post-clear delay, then init_done with the first refresh byte ----
        for (int j = 0; j < CLEAR; j++) begin
            check("clr_delay_done",  32'(bus.init_done), 32'd0);
            check("clr_delay_start", 32'(bus.wr_start),  32'd0);
            @(negedge clk);
        end
        check("init_done_set", 32'(bus.init_done), 32'd1);

        // ---- refresh lap 1: buffer 0x41.. ----
        build_lap();
        for (int r = 0; r < 34; r++)
            do_write(exp_q[r], 3, 1'b0, -1, 1'b1, "ref1");

        // ---- refresh lap 2: random buffer and latencies, one 50-cycle write,
        //      one wr_finish coinciding with wr_start ----
        for (int i = 0; i < 32; i++)
            mem[i] = 8'($urandom_range(255, 0));
        build_lap();
        for (int r = 0; r < 34; r++) begin
            lat = (r == 5) ? 50 : int'($urandom_range(6, 2));
            do_write(exp_q[r], lat, (r == 7), -1, 1'b1, "ref2");
        end

        // ---- lap 3: drop enable in the middle of a write ----
        build_lap();
        for (int r = 0; r < 4; r++)
            do_write(exp_q[r], (r == 3) ? 6 : 2, 1'b0, (r == 3) ? 2 : -1, 1'b1, "ref3");
        check("disable_init_done", 32'(bus.init_done), 32'd0);
        check("disable_no_start",  32'(bus.wr_start),  32'd0);
        repeat (4) begin
            @(negedge clk);
            check("disabled_no_start", 32'(bus.wr_start),  32'd0);
            check("disabled_done",     32'(bus.init_done), 32'd0);
        end

        // ---- re-enable restarts from the power-up wait ----
        bus.lcd_enable = 1'b1;
        wait_first_start(-1, k);
        check("reenable_latency", 32'(k), 32'(POWERUP + 1));
        check("reenable_data",    32'(bus.wr_data), 32'h38);
        check("reenable_rs",      32'(bus.wr_rs),   32'd0);

        // ---- asynchronous reset in the middle of INIT_WAIT ----
        repeat (2) @(negedge clk);
        check("init_wait_data", 32'(bus.wr_data), 32'h38);
        #2;
        rst = 1'b1;
        #1;
        check("async_wr_start",  32'(bus.wr_start),  32'd0);
        check("async_wr_data",   32'(bus.wr_data),   32'h00);
        check("async_wr_rs",     32'(bus.wr_rs),     32'd0);
        check("async_init_done", 32'(bus.init_done), 32'd0);
        check("async_char_addr", 32'(bus.char_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_first_start(-1, k);
        check("post_reset_latency", 32'(k), 32'(POWERUP + 1));
        check("post_reset_data",    32'(bus.wr_data), 32'h38);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_init_refresh.md
Name: lcd_init_refresh

Overview:
Sequencer for an HD44780-compatible 16x2 character LCD in 8-bit mode. After `lcd_enable` it performs the power-up wait and the init command sequence. It then continuously refreshes both display lines from an external 32-byte character buffer. It sits above a byte-level LCD write module: it issues one byte per `wr_start` request and waits for that module's `wr_finish`.

Parameters:
- POWERUP_CYCLES, 750000: clk cycles to wait after enable before the first command (15 ms at 50 MHz).
- CLEAR_CYCLES, 82000: clk cycles to wait after the clear-display command completes (1.64 ms).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- lcd_enable  in  1  level; high = run init, then refresh; low = go idle.
- wr_finish  in  1  one-cycle pulse from the write module: current byte has been written.
- wr_start  out  1  one-cycle pulse requesting a byte write.
- wr_data  out  8  byte to write; stable from the `wr_start` pulse until `wr_finish`.
- wr_rs  out  1  0 = command, 1 = character data; same stability rule as `wr_data`.
- char_addr  out  5  character buffer address (0..15 = line 1, 16..31 = line 2).
- char_data  in  8  combinational (asynchronous-read) buffer output for `char_addr`.
- init_done  out  1  high once the init sequence has completed; stays high while refreshing.

Behaviour:
- Reset values:
  - state IDLE; `wr_start`=0, `wr_data`=0x00, `wr_rs`=0, `char_addr`=0, `init_done`=0.
  - Counters and indices are 0.
- IDLE: when `lcd_enable`=1, go to PWR_WAIT and clear the delay counter.
- PWR_WAIT: count POWERUP_CYCLES cycles, then go to INIT_ISSUE with init index 0.
- Init commands, all with rs=0, in order: 0x38 (function set), 0x06 (entry mode), 0x0C (display on), 0x01 (clear).
- INIT_ISSUE (1 cycle): pulse `wr_start`; load `wr_data` = cmd[idx] and `wr_rs`=0; go to INIT_WAIT.
- INIT_WAIT: hold outputs until `wr_finish`=1. Then:
  - if idx<3: idx++ and go to INIT_ISSUE;
  - if idx=3 (clear just completed): go to CLR_DELAY.
- CLR_DELAY: count CLEAR_CYCLES cycles, then set `init_done`=1 and go to REF_ISSUE with refresh index r=0.
- Refresh index r runs 0..33:
  - r=0: command 0x80 (rs=0);
  - r=1..16: character from buffer address r-1 (rs=1);
  - r=17: command 0xC0 (rs=0);
  - r=18..33: character from buffer address r-2 (rs=1).
- `char_addr` is driven from r combinationally in REF_ISSUE. `char_data` is sampled into `wr_data` on the `wr_start` cycle.
- REF_ISSUE (1 cycle): pulse `wr_start` with the byte for r; go to REF_WAIT.
- REF_WAIT: on `wr_finish`, r = (r==33) ? 0 : r+1 and go to REF_ISSUE. Refresh wraps forever.
- Gap between `wr_finish` and the next `wr_start`: exactly 1 cycle (the ISSUE state).
- `wr_finish` outside the WAIT states is ignored.
- `wr_finish` in the same cycle as `wr_start` is ignored; it is only accepted from the cycle after issue.
- `lcd_enable` falling:
  - in PWR_WAIT, CLR_DELAY or either ISSUE state: go to IDLE on the next edge;
  - in a WAIT state: finish the outstanding write (wait for `wr_finish`), then go to IDLE.
  - On entering IDLE, clear `init_done`. Re-enabling always restarts the full init from PWR_WAIT.
- Asynchronous reset at any time returns every output to its reset value immediately; no write is completed.
- Delay counters are 20 bits wide; a terminal count of 0 is treated as 1 cycle.

Decomposition:
- Package lcd_pkg holds:
  - the state enum;
  - init command constants (0x38, 0x06, 0x0C, 0x01);
  - line address commands (0x80, 0xC0);
  - the refresh length constant (34).
- One sub-module, lcd_delay_timer: start/terminal-count input, done pulse output. Used for both the power-up and clear delays.

Test Plan:
- Power-up: POWERUP_CYCLES=10, CLEAR_CYCLES=5; raise `lcd_enable`. First `wr_start` comes 10 cycles after PWR_WAIT entry, with `wr_data`=0x38 and `wr_rs`=0; no `wr_start` occurs before then.
- Init order: answer each `wr_start` with `wr_finish` 3 cycles later.
  - Bytes must be 0x38, 0x06, 0x0C, 0x01, all with rs=0.
  - After the 0x01 finish: 5 idle cycles, then `init_done`=1.
- Refresh: buffer[i] = 0x41+i.
  - Sequence must be 0x80 (rs0), 0x41..0x50 (rs1), 0xC0 (rs0), 0x51..0x60 (rs1), then 0x80 again.
  - `char_addr` must be 0..31 in order.
- Handshake: delay `wr_finish` by 50 cycles.
  - `wr_data` and `wr_rs` stay stable and there is no second `wr_start`.
  - A stray `wr_finish` during PWR_WAIT is ignored.
- Disable: drop `lcd_enable` mid REF_WAIT. The FSM stays until `wr_finish`, then goes IDLE with `init_done`=0. Re-enable restarts with the 10-cycle wait, then 0x38.
- Reset: assert `rst` during INIT_WAIT. `wr_start`, `init_done` and `wr_data` go to 0 immediately, without waiting for a clk edge.
